// File: rtl/switch_alloc_credit_ctrl.sv
// switch_alloc_credit_ctrl
//
// Per-router switch allocator with downstream credit tracking. Sits between the
// per-input VC priority stage and the crossbar. Every output port is arbitrated
// independently:
//   - IDLE:   round-robin pick among the inputs requesting this output, starting
//             at rr_ptr. A non-tail winner locks the output to itself.
//   - LOCKED: only the owner may transfer; its tail flit releases the lock and
//             advances rr_ptr past the owner.
// A transfer needs at least one downstream credit. Each grant consumes a credit,
// and each credit_in pulse returns one.
//
// Ports (index 0 is the leftmost element/slice of every vector):
//   clk            router clock
//   reset          synchronous, active-high reset
//   req[i]         input i has a flit waiting
//   req_dest       slice i (IDX_W bits): output requested by input i
//   req_tail[i]    flit at input i is a tail or single-flit packet
//   credit_in[o]   one-cycle credit return for output o
//   grant[i]       input i transfers at this rising edge
//   out_valid[o]   output o carries a flit this cycle
//   out_sel        slice o (IDX_W bits): input driving output o, 0 when idle
//   out_locked[o]  output o is reserved mid-packet
//   credits        slice o (CNT_W bits): current credit count of output o
//   err_credit_ovf sticky: credit returned while a counter was already full
module switch_alloc_credit_ctrl #(
  parameter int unsigned PORTS      = 7,
  parameter int unsigned IDX_W      = 3,
  parameter int unsigned CREDIT_MAX = 4,
  parameter int unsigned CNT_W      = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [0:PORTS-1]       req,
  input  logic [0:IDX_W*PORTS-1] req_dest,
  input  logic [0:PORTS-1]       req_tail,
  input  logic [0:PORTS-1]       credit_in,
  output logic [0:PORTS-1]       grant,
  output logic [0:PORTS-1]       out_valid,
  output logic [0:IDX_W*PORTS-1] out_sel,
  output logic [0:PORTS-1]       out_locked,
  output logic [0:CNT_W*PORTS-1] credits,
  output logic                   err_credit_ovf
);

  typedef enum logic {
    StIdle,
    StLocked
  } st_e;

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(CREDIT_MAX);

  // (base + k) mod PORTS, used for the round-robin scan and pointer update.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                               input int unsigned     k);
    int unsigned sum;
    sum = 32'(base) + k;
    return IDX_W'(sum % PORTS);
  endfunction

  // Per-output registered state.
  st_e              st_q    [PORTS];
  st_e              st_d    [PORTS];
  logic [IDX_W-1:0] owner_q [PORTS];
  logic [IDX_W-1:0] owner_d [PORTS];
  logic [IDX_W-1:0] rr_q    [PORTS];
  logic [IDX_W-1:0] rr_d    [PORTS];
  logic [CNT_W-1:0] cnt_q   [PORTS];
  logic [CNT_W-1:0] cnt_d   [PORTS];
  logic             err_q;
  logic             err_d;

  // cand[o][i]: input i is requesting output o. A destination >= PORTS never
  // matches any o, so such requests are silently ignored.
  logic [PORTS-1:0] cand [PORTS];

  // Arbitration result per output.
  logic [PORTS-1:0] win_vld;
  logic [IDX_W-1:0] win_idx [PORTS];

  always_comb begin
    for (int unsigned o = 0; o < PORTS; o++) begin
      cand[o] = '0;
      for (int unsigned i = 0; i < PORTS; i++) begin
        cand[o][i] = req[i] && (req_dest[i*IDX_W +: IDX_W] == IDX_W'(o));
      end
    end
  end

  // Arbitration. Winners are suppressed during reset and when out of credits,
  // which also guarantees the counter never decrements from zero.
  always_comb begin
    win_vld = '0;
    for (int unsigned o = 0; o < PORTS; o++) begin
      win_idx[o] = '0;
      if (!reset && (cnt_q[o] != '0)) begin
        if (st_q[o] == StLocked) begin
          if (cand[o][owner_q[o]]) begin
            win_vld[o] = 1'b1;
            win_idx[o] = owner_q[o];
          end
        end else begin
          // Scan from the far end back towards rr_ptr so the last hit written
          // is the first candidate at or after rr_ptr.
          for (int k = int'(PORTS) - 1; k >= 0; k--) begin
            if (cand[o][wrap_add(rr_q[o], unsigned'(k))]) begin
              win_vld[o] = 1'b1;
              win_idx[o] = wrap_add(rr_q[o], unsigned'(k));
            end
          end
        end
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned o = 0; o < PORTS; o++) begin
        st_q[o]    <= StIdle;
        owner_q[o] <= '0;
        rr_q[o]    <= '0;
        cnt_q[o]   <= CntMax;
      end
      err_q <= 1'b0;
    end else begin
      for (int unsigned o = 0; o < PORTS; o++) begin
        st_q[o]    <= st_d[o];
        owner_q[o] <= owner_d[o];
        rr_q[o]    <= rr_d[o];
        cnt_q[o]   <= cnt_d[o];
      end
      err_q <= err_d;
    end
  end

  // Next-state logic: lock/unlock, round-robin pointer and credit counters.
  always_comb begin
    err_d = err_q;
    for (int unsigned o = 0; o < PORTS; o++) begin
      st_d[o]    = st_q[o];
      owner_d[o] = owner_q[o];
      rr_d[o]    = rr_q[o];
      cnt_d[o]   = cnt_q[o];

      if (win_vld[o]) begin
        if (req_tail[win_idx[o]]) begin
          st_d[o] = StIdle;
          rr_d[o] = wrap_add(win_idx[o], 1);
        end else begin
          st_d[o]    = StLocked;
          owner_d[o] = win_idx[o];
        end
      end

      // A grant and a returned credit in the same cycle cancel out.
      case ({win_vld[o], credit_in[o]})
        2'b10: cnt_d[o] = cnt_q[o] - CNT_W'(1);
        2'b01: begin
          if (cnt_q[o] == CntMax) begin
            err_d = 1'b1;
          end else begin
            cnt_d[o] = cnt_q[o] + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs. Status outputs read their reset values while reset is held so
  // the crossbar never sees a stale lock or count during reset.
  always_comb begin
    grant      = '0;
    out_valid  = '0;
    out_sel    = '0;
    out_locked = '0;
    credits    = '0;
    for (int unsigned o = 0; o < PORTS; o++) begin
      if (win_vld[o]) begin
        grant[win_idx[o]]            = 1'b1;
        out_valid[o]                 = 1'b1;
        out_sel[o*IDX_W +: IDX_W]    = win_idx[o];
      end
      out_locked[o]                  = !reset && (st_q[o] == StLocked);
      credits[o*CNT_W +: CNT_W]      = reset ? CntMax : cnt_q[o];
    end
    err_credit_ovf = err_q && !reset;
  end

endmodule

// File: tb/tb_switch_alloc_credit_ctrl.sv
module tb_switch_alloc_credit_ctrl;

  localparam int P  = 7;
  localparam int W  = 3;
  localparam int CM = 4;
  localparam int CW = 3;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [0:P-1]   req = '0;
  logic [0:W*P-1] req_dest = '0;
  logic [0:P-1]   req_tail = '0;
  logic [0:P-1]   credit_in = '0;
  logic [0:P-1]   grant;
  logic [0:P-1]   out_valid;
  logic [0:W*P-1] out_sel;
  logic [0:P-1]   out_locked;
  logic [0:CW*P-1] credits;
  logic           err_credit_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: per output a locked flag, owner, round-robin start and
  // credit count, plus the sticky error.
  bit m_valid = 1'b0;
  int m_locked [P];
  int m_owner  [P];
  int m_rr     [P];
  int m_cnt    [P];
  bit m_err;
  int exp_win  [P];

  int rr_seq [5] = '{1, 3, 5, 1, -1};

  switch_alloc_credit_ctrl #(
    .PORTS     (P),
    .IDX_W     (W),
    .CREDIT_MAX(CM),
    .CNT_W     (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .req_dest      (req_dest),
    .req_tail      (req_tail),
    .credit_in     (credit_in),
    .grant         (grant),
    .out_valid     (out_valid),
    .out_sel       (out_sel),
    .out_locked    (out_locked),
    .credits       (credits),
    .err_credit_ovf(err_credit_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_cand(input int i, input int o);
    return req[i] && (int'(req_dest[i*W +: W]) == o);
  endfunction

  function automatic logic [0:P-1] oh(input int i);
    logic [0:P-1] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  function automatic int cr(input int o);
    return int'(credits[o*CW +: CW]);
  endfunction

  // Compare process: expected outputs from the model, checked every cycle.
  always @(negedge clk) begin : cmp
    logic [0:P-1]    eg;
    logic [0:P-1]    ev;
    logic [0:P-1]    el;
    logic [0:W*P-1]  es;
    logic [0:CW*P-1] ec;
    if (m_valid) begin
      eg = '0;
      ev = '0;
      el = '0;
      es = '0;
      ec = '0;
      for (int o = 0; o < P; o++) begin
        exp_win[o] = -1;
        if (!reset && m_cnt[o] > 0) begin
          if (m_locked[o] != 0) begin
            if (is_cand(m_owner[o], o)) exp_win[o] = m_owner[o];
          end else begin
            for (int k = 0; k < P; k++) begin
              if (exp_win[o] < 0 && is_cand((m_rr[o] + k) % P, o)) exp_win[o] = (m_rr[o] + k) % P;
            end
          end
        end
        if (exp_win[o] >= 0) begin
          eg[exp_win[o]] = 1'b1;
          ev[o]          = 1'b1;
          es[o*W +: W]   = W'(exp_win[o]);
        end
        el[o]          = !reset && (m_locked[o] != 0);
        ec[o*CW +: CW] = reset ? CW'(CM) : CW'(m_cnt[o]);
      end
      check("model_grant", 64'(grant), 64'(eg));
      check("model_out_valid", 64'(out_valid), 64'(ev));
      check("model_out_sel", 64'(out_sel), 64'(es));
      check("model_out_locked", 64'(out_locked), 64'(el));
      check("model_credits", 64'(credits), 64'(ec));
      check("model_err", 64'(err_credit_ovf), 64'(m_err && !reset));
    end
  end

  // Model update at the committing edge.
  always @(posedge clk) begin
    if (reset) begin
      for (int o = 0; o < P; o++) begin
        m_locked[o] <= 0;
        m_owner[o]  <= 0;
        m_rr[o]     <= 0;
        m_cnt[o]    <= CM;
        exp_win[o]  <= -1;
      end
      m_err   <= 1'b0;
      m_valid <= 1'b1;
    end else if (m_valid) begin
      for (int o = 0; o < P; o++) begin
        if (exp_win[o] >= 0) begin
          if (req_tail[exp_win[o]]) begin
            m_locked[o] <= 0;
            m_rr[o]     <= (exp_win[o] + 1) % P;
          end else begin
            m_locked[o] <= 1;
            m_owner[o]  <= exp_win[o];
          end
          if (!credit_in[o]) m_cnt[o] <= m_cnt[o] - 1;
        end else if (credit_in[o]) begin
          if (m_cnt[o] == CM) m_err <= 1'b1;
          else m_cnt[o] <= m_cnt[o] + 1;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    req       = '0;
    req_tail  = '0;
    credit_in = '0;
    req_dest  = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clr();
    cyc();
    reset = 1'b0;
  endtask

  task automatic set_req(input int i, input int d, input bit t);
    req[i]          = 1'b1;
    req_dest[i*W +: W] = W'(d);
    req_tail[i]     = t;
  endtask

  initial begin
    logic [0:CW*P-1] all_max;
    int d [P];
    for (int o = 0; o < P; o++) all_max[o*CW +: CW] = CW'(CM);

    // Reset with every input requesting.
    reset = 1'b1;
    req   = '1;
    for (int i = 0; i < P; i++) req_dest[i*W +: W] = W'($urandom_range(0, P - 1));
    repeat (2) begin
      @(negedge clk);
      check("rst_grant", 64'(grant), 64'(0));
      check("rst_credits", 64'(credits), 64'(all_max));
      check("rst_err", 64'(err_credit_ovf), 64'(0));
    end
    cyc();
    reset = 1'b0;
    clr();

    // Round-robin among inputs 1, 3, 5 on output 2.
    do_reset();
    set_req(1, 2, 1);
    set_req(3, 2, 1);
    set_req(5, 2, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("rr_grant", 64'(grant), 64'(oh(rr_seq[k])));
      check("rr_cnt", 64'(cr(2)), 64'(4 - k));
      cyc();
    end

    // Packet lock: 3-flit packet from input 0 to output 4, input 6 waiting.
    do_reset();
    set_req(0, 4, 0);
    set_req(6, 4, 1);
    @(negedge clk);
    check("lock_g1", 64'(grant), 64'(oh(0)));
    cyc();
    @(negedge clk);
    check("lock_g2", 64'(grant), 64'(oh(0)));
    check("lock_l2", 64'(out_locked[4]), 64'(1));
    cyc();
    req_tail[0] = 1'b1;
    @(negedge clk);
    check("lock_g3", 64'(grant), 64'(oh(0)));
    check("lock_l3", 64'(out_locked[4]), 64'(1));
    check("lock_sel3", 64'(out_sel[4*W +: W]), 64'(0));
    cyc();
    req[0] = 1'b0;
    @(negedge clk);
    check("lock_g4", 64'(grant), 64'(oh(6)));
    check("lock_sel4", 64'(out_sel[4*W +: W]), 64'(6));
    check("lock_l4", 64'(out_locked[4]), 64'(0));
    check("lock_cnt4", 64'(cr(4)), 64'(1));
    cyc();

    // Round-robin pointer wraps after granting input 6.
    do_reset();
    set_req(6, 3, 1);
    @(negedge clk);
    check("wrap_g6", 64'(grant), 64'(oh(6)));
    cyc();
    set_req(0, 3, 1);
    @(negedge clk);
    check("wrap_g0", 64'(grant), 64'(oh(0)));
    cyc();

    // Credit stall and return on output 1.
    do_reset();
    set_req(2, 1, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("drain_grant", 64'(grant), 64'(oh(2)));
      check("drain_cnt", 64'(cr(1)), 64'(4 - k));
      cyc();
    end
    credit_in[1] = 1'b1;
    @(negedge clk);
    check("stall_grant", 64'(grant), 64'(0));
    check("stall_cnt", 64'(cr(1)), 64'(0));
    cyc();
    credit_in[1] = 1'b0;
    @(negedge clk);
    check("ret_grant", 64'(grant), 64'(oh(2)));
    check("ret_cnt", 64'(cr(1)), 64'(1));
    cyc();
    credit_in[1] = 1'b1;
    @(negedge clk);
    check("ret2_grant", 64'(grant), 64'(0));
    cyc();
    @(negedge clk);
    check("both_grant", 64'(grant), 64'(oh(2)));
    check("both_cnt", 64'(cr(1)), 64'(1));
    cyc();
    credit_in[1] = 1'b0;
    @(negedge clk);
    check("both_after_cnt", 64'(cr(1)), 64'(1));
    check("both_after_grant", 64'(grant), 64'(oh(2)));
    cyc();
    @(negedge clk);
    check("final_cnt", 64'(cr(1)), 64'(0));
    check("final_grant", 64'(grant), 64'(0));
    cyc();

    // Overflow on output 5.
    do_reset();
    credit_in[5] = 1'b1;
    @(negedge clk);
    check("ovf_pre_err", 64'(err_credit_ovf), 64'(0));
    cyc();
    credit_in[5] = 1'b0;
    @(negedge clk);
    check("ovf_cnt", 64'(cr(5)), 64'(4));
    check("ovf_err", 64'(err_credit_ovf), 64'(1));
    repeat (3) cyc();
    @(negedge clk);
    check("ovf_sticky", 64'(err_credit_ovf), 64'(1));
    cyc();
    do_reset();
    @(negedge clk);
    check("ovf_cleared", 64'(err_credit_ovf), 64'(0));
    cyc();

    // Out-of-range destination.
    do_reset();
    set_req(3, 7, 1);
    @(negedge clk);
    check("dest7_grant", 64'(grant), 64'(0));
    check("dest7_valid", 64'(out_valid), 64'(0));
    cyc();

    // Reset in the middle of a packet.
    do_reset();
    set_req(0, 4, 0);
    @(negedge clk);
    check("mid_g", 64'(grant), 64'(oh(0)));
    cyc();
    @(negedge clk);
    check("mid_locked", 64'(out_locked[4]), 64'(1));
    cyc();
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_grant", 64'(grant), 64'(0));
    cyc();
    reset = 1'b0;
    @(negedge clk);
    check("mid_unlocked", 64'(out_locked[4]), 64'(0));
    check("mid_regrant", 64'(grant), 64'(oh(0)));
    check("mid_cnt", 64'(cr(4)), 64'(4));
    cyc();

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < P; i++) d[i] = $urandom_range(0, P - 1);
    repeat (3000) begin
      reset = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < P; i++) begin
        if ($urandom_range(0, 4) == 0) d[i] = ($urandom_range(0, 15) == 0) ? 7 : $urandom_range(0, P - 1);
        req[i]             = ($urandom_range(0, 9) < 7);
        req_dest[i*W +: W] = W'(d[i]);
        req_tail[i]        = ($urandom_range(0, 2) == 0);
        credit_in[i]       = ($urandom_range(0, 9) < 3);
      end
      cyc();
    end
    reset = 1'b0;
    clr();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
